vld_fetch_engine: RTL

VLD_FETCH_ENGINE -- requirements
Module: vld_fetch_engine

---
 rtl/vld_fetch_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vld_fetch_engine.sv
// Miss-driven block fetch engine: dedups misses into a small FIFO and
// fetches one multi-beat block at a time, emitting a fill/update pulse.
module vld_fetch_engine #(
    parameter int ADDR_BITS      = 32,
    parameter int BLOCK_ID_START = 5,
    parameter int MEM_DW         = 32,
    parameter int BEATS          = 8,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_valid_i,
    input  logic [ADDR_BITS-1:0]      miss_address_i,
    output logic                      miss_ready_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic [ADDR_BITS-1:0]      mem_req_address_o,
    input  logic                      mem_resp_valid_i,
    input  logic [MEM_DW-1:0]         mem_resp_data_i,
    output logic                      fill_valid_o,
    output logic [ADDR_BITS-1:0]      fill_address_o,
    output logic [BEATS*MEM_DW-1:0]   fill_data_o,
    output logic                      valid_update_o,
    output logic [ADDR_BITS-1:0]      update_address_o,
    output logic                      busy_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_BITS-1:0] LOW_MASK =
        (ADDR_BITS'(1) << BLOCK_ID_START) - ADDR_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic [ADDR_BITS-1:0]      r_q [DEPTH];
    logic [DEPTH-1:0]          r_vld;
    logic [PW-1:0]             r_head;
    logic [PW-1:0]             r_tail;
    logic [CW-1:0]             r_count;
    logic [BW-1:0]             r_beat;
    logic                      r_req;
    logic                      r_done;
    logic [ADDR_BITS-1:0]      r_addr;
    logic [BEATS*MEM_DW-1:0]   r_data;

    logic                      w_hit;
    logic                      w_ready;
    logic                      w_push;
    logic                      w_pop;
    logic [ADDR_BITS-1:0]      w_blk;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The head leaves in DONE, so a same-block miss then needs a fresh entry.
    always_comb begin
        w_blk = miss_address_i & ~LOW_MASK;
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_q[i] == w_blk) &&
                !((r_state == S_DONE) && (PW'(i) == r_head))) begin
                w_hit = 1'b1;
            end
        end
        w_ready = (r_count < CW'(DEPTH)) || w_hit;
        w_push  = miss_valid_i && w_ready && !w_hit;
        w_pop   = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= f_next(r_head);
            end
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= f_next(r_tail);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            unique case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_q[r_head];
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        r_state <= S_RESP;
                        r_req   <= 1'b0;
                        r_beat  <= '0;
                    end
                end
                S_RESP: begin
                    if (mem_resp_valid_i) begin
                        r_beat <= r_beat + BW'(1);
                        if (r_beat == BW'(BEATS - 1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_q[r_tail] <= w_blk;
        end
        if ((r_state == S_RESP) && mem_resp_valid_i) begin
            r_data[int'(r_beat) * MEM_DW +: MEM_DW] <= mem_resp_data_i;
        end
    end

    assign miss_ready_o      = w_ready;
    assign mem_req_valid_o   = r_req;
    assign mem_req_address_o = r_addr;
    assign fill_valid_o      = r_done;
    assign fill_address_o    = r_addr;
    assign fill_data_o       = r_data;
    assign valid_update_o    = r_done;
    assign update_address_o  = r_addr;
    assign busy_o            = (r_count != '0) || (r_state != S_IDLE);

endmodule
